// File: rtl/memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared types and constants for the data memory controller slice.
//   state_e      : controller FSM state (INIT = clearing / waiting, RUN = serving)
//   offs_f()     : number of byte-offset bits in a word address
//   DEF_*        : default parameter values used by the controller and its bank
// -----------------------------------------------------------------------------
package memory_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_DATA_W         = 32;
    localparam int DEF_ADDR_W         = 32;
    localparam int DEF_DEPTH          = 512;
    localparam int DEF_CLEAR_ON_RESET = 1;

    // Byte-offset bits inside one word: log2(bytes per word).
    function automatic int offs_f(input int data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/mem_bank.sv
// -----------------------------------------------------------------------------
// mem_bank
// DEPTH x DATA_W storage array with one byte-writable write port and one
// registered read port sharing a single word address.
// Ports:
//   clk_i    : clock
//   we_i     : write enable; bytes selected by be_i are written at addr_i
//   re_i     : read enable; rdata_o loads mem[addr_i] on the rising edge
//   addr_i   : word index
//   wdata_i  : write data
//   be_i     : per-byte write enables
//   rdata_o  : registered read data, holds its value while re_i is low
// -----------------------------------------------------------------------------
module mem_bank
    import memory_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [$clog2(DEPTH)-1:0]  addr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic [DATA_W/8-1:0]       be_i,
    output logic [DATA_W-1:0]         rdata_o
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_p1;

    // ---- stage p0 -> p1: array write and registered read ----
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (be_i[b]) begin
                    mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_p1 <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_p1;

endmodule

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Word-addressed, byte-writable data memory for the load/store unit with a
// valid/ready request channel and a single-entry valid/ready response channel.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  : request handshake (ready only in RUN with room)
//   req_we_i                 : 1 = write, 0 = read
//   req_addr_i               : byte address (must be word aligned, in range)
//   req_wdata_i, req_be_i    : write data and byte enables
//   rsp_valid_o/rsp_ready_i  : response handshake
//   rsp_rdata_o              : read data (0 for writes and errors)
//   rsp_err_o                : misaligned or out-of-range request
//   init_done_o              : high once the post-reset clear has completed
// -----------------------------------------------------------------------------
module data_memory_ctrl
    import memory_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int CLEAR_ON_RESET = DEF_CLEAR_ON_RESET
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [DATA_W/8-1:0]   req_be_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_done_o
);

    localparam int NB   = DATA_W / 8;
    localparam int OFFS = offs_f(DATA_W);
    localparam int AW   = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            clr_we;

    logic            accept;
    logic            misaligned;
    logic            out_of_range;
    logic            bad;
    logic [63:0]     idx_ext;
    logic [ADDR_W-1:0] offs_mask;

    logic            bank_we;
    logic            bank_re;
    logic [AW-1:0]   bank_addr;
    logic [DATA_W-1:0] bank_wdata;
    logic [NB-1:0]   bank_be;
    logic [DATA_W-1:0] bank_rdata;

    logic            rsp_vld_p1;
    logic            rsp_err_p1;
    logic            rsp_rd_p1;

    // ---- control FSM: INIT clears the array word by word, RUN serves ----
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == AW'(DEPTH - 1)) begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = RUN;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    assign init_done_o = (state_q == RUN);

    // ---- request decode (stage p0) ----
    // The index is widened before comparing so that any ADDR_W/DEPTH pairing
    // compares correctly; addresses whose index lies beyond DEPTH never alias.
    assign idx_ext      = 64'(req_addr_i) >> OFFS;
    assign out_of_range = (idx_ext >= 64'(DEPTH));
    assign offs_mask    = ADDR_W'(NB - 1);
    assign misaligned   = |(req_addr_i & offs_mask);
    assign bad          = misaligned | out_of_range;

    // A new request fits whenever the response slot is empty or drains now.
    assign req_ready_o  = (state_q == RUN) && (!rsp_vld_p1 || rsp_ready_i);
    assign accept       = req_valid_i && req_ready_o;

    // Clear writes own the bank port during INIT; no request can be accepted then.
    assign bank_we    = clr_we | (accept & req_we_i & ~bad);
    assign bank_re    = accept & ~req_we_i & ~bad;
    assign bank_addr  = (state_q == INIT) ? cnt_q : req_addr_i[OFFS +: AW];
    assign bank_wdata = (state_q == INIT) ? '0 : req_wdata_i;
    assign bank_be    = (state_q == INIT) ? '1 : req_be_i;

    mem_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_bank (
        .clk_i   (clk_i),
        .we_i    (bank_we),
        .re_i    (bank_re),
        .addr_i  (bank_addr),
        .wdata_i (bank_wdata),
        .be_i    (bank_be),
        .rdata_o (bank_rdata)
    );

    // ---- stage p0 -> p1: response slot ----
    // rsp_rd_p1 marks a successful read; the bank register only reloads on
    // such reads, so it holds steady under backpressure and is masked otherwise.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_vld_p1 <= 1'b0;
            rsp_err_p1 <= 1'b0;
            rsp_rd_p1  <= 1'b0;
        end else if (accept) begin
            rsp_vld_p1 <= 1'b1;
            rsp_err_p1 <= bad;
            rsp_rd_p1  <= ~req_we_i & ~bad;
        end else if (rsp_ready_i) begin
            rsp_vld_p1 <= 1'b0;
            rsp_err_p1 <= 1'b0;
            rsp_rd_p1  <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_vld_p1;
    assign rsp_err_o   = rsp_err_p1;
    assign rsp_rdata_o = rsp_rd_p1 ? bank_rdata : '0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
// Directed bench for data_memory_ctrl with default parameters
// (DATA_W 32, ADDR_W 32, DEPTH 512, CLEAR_ON_RESET 1).
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_be_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        init_done_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    data_memory_ctrl dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_be_i    (req_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .init_done_o (init_done_o)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One request with rsp_ready_i high; returns the response seen the cycle after acceptance.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rd, output logic er,
                          output logic ok);
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_be_i    = be;
        rsp_ready_i = 1'b1;
        ok = 1'b0;
        rd = '0;
        er = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (ok) begin
            @(posedge clk_i);
            #1;
            req_valid_i = 1'b0;
            rd = rsp_rdata_o;
            er = rsp_err_o;
            ok = rsp_valid_o;
        end else begin
            req_valid_i = 1'b0;
        end
    endtask

    // Release reset at a falling edge and count rising edges until init_done_o.
    task automatic count_init(input string name, input logic watch_leak);
        int  cyc;
        logic leak;
        cyc  = 0;
        leak = 1'b0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk_i);
            #1;
            cyc++;
            if (init_done_o) break;
            if (req_ready_o || rsp_valid_o) leak = 1'b1;
        end
        req_valid_i = 1'b0;
        chk({name, "_cycles"}, cyc, 512);
        if (watch_leak) chk({name, "_no_accept"}, {31'b0, leak}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        ok;

        vecs[0]  = '{1'b0, 32'h0000_07FC, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 32'hDEAD_BEAA, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0012, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h0000_0800, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[10] = '{1'b1, 32'h0000_0018, 32'h1234_5678, 4'hA, 32'h0000_0000, 1'b0};
        vecs[11] = '{1'b0, 32'h0000_0018, 32'h0,         4'h0, 32'h1200_5600, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0011, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[13] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'h0, 32'h0000_0000, 1'b1};
        vecs[14] = '{1'b1, 32'h0000_07FC, 32'hA5A5_5A5A, 4'hF, 32'h0000_0000, 1'b0};
        vecs[15] = '{1'b0, 32'h0000_07FC, 32'h0,         4'h0, 32'hA5A5_5A5A, 1'b0};

        rst_ni      = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_be_i    = '0;
        rsp_ready_i = 1'b1;

        // Reset state
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_req_ready", {31'b0, req_ready_o}, 0);
        chk("rst_rsp_valid", {31'b0, rsp_valid_o}, 0);
        chk("rst_rsp_rdata", rsp_rdata_o, 0);
        chk("rst_rsp_err",   {31'b0, rsp_err_o}, 0);
        chk("rst_init_done", {31'b0, init_done_o}, 0);

        // Hold a write to word 1 through INIT: it must not be accepted.
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h4;
        req_wdata_i = 32'hFFFF_FFFF;
        req_be_i    = 4'hF;
        count_init("init1", 1'b1);

        // Table of single requests
        for (int i = 0; i < 16; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, rd, er, ok);
            chk($sformatf("vec%0d_valid", i), {31'b0, ok}, 1);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i),   {31'b0, er}, {31'b0, vecs[i].exp_err});
        end

        // Back-to-back write then read of 0x20
        @(negedge clk_i);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h20;
        req_wdata_i = 32'h0BAD_F00D;
        req_be_i    = 4'hF;
        @(posedge clk_i);
        #1;
        chk("b2b_wr_valid", {31'b0, rsp_valid_o}, 1);
        chk("b2b_wr_rdata", rsp_rdata_o, 0);
        chk("b2b_ready",    {31'b0, req_ready_o}, 1);
        req_we_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("b2b_rd_valid", {31'b0, rsp_valid_o}, 1);
        chk("b2b_rd_rdata", rsp_rdata_o, 32'h0BAD_F00D);
        chk("b2b_rd_err",   {31'b0, rsp_err_o}, 0);
        @(posedge clk_i);
        #1;
        chk("b2b_drain", {31'b0, rsp_valid_o}, 0);

        // Backpressure: read 0x10 stalled for 3 cycles, read 0x18 waiting
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 32'h10;
        @(posedge clk_i);
        #1;
        req_addr_i = 32'h18;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk($sformatf("bp%0d_valid", c), {31'b0, rsp_valid_o}, 1);
            chk($sformatf("bp%0d_rdata", c), rsp_rdata_o, 32'hDEAD_BEAA);
            chk($sformatf("bp%0d_ready", c), {31'b0, req_ready_o}, 0);
        end
        rsp_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, req_ready_o}, 1);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("bp_next_valid", {31'b0, rsp_valid_o}, 1);
        chk("bp_next_rdata", rsp_rdata_o, 32'h1200_5600);
        @(posedge clk_i);
        #1;
        chk("bp_drain", {31'b0, rsp_valid_o}, 0);

        // Reset with a pending response, then reset again at init cycle 100
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        req_addr_i  = 32'h10;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        chk("pend_valid", {31'b0, rsp_valid_o}, 1);
        chk("pend_rdata", rsp_rdata_o, 32'hDEAD_BEAA);
        #2 rst_ni = 1'b0;
        #1;
        chk("arst_rsp_valid", {31'b0, rsp_valid_o}, 0);
        chk("arst_rsp_rdata", rsp_rdata_o, 0);
        chk("arst_init_done", {31'b0, init_done_o}, 0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        rsp_ready_i = 1'b1;
        repeat (100) @(posedge clk_i);
        #1;
        chk("init100_done", {31'b0, init_done_o}, 0);
        rst_ni = 1'b0;
        #1;
        chk("init100_rst_ready", {31'b0, req_ready_o}, 0);
        chk("init100_rst_done",  {31'b0, init_done_o}, 0);
        count_init("init2", 1'b0);

        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, ok);
        chk("post_clr_10_valid", {31'b0, ok}, 1);
        chk("post_clr_10_rdata", rd, 0);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, ok);
        chk("post_clr_20_rdata", rd, 0);
        chk("post_clr_20_err",   {31'b0, er}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
Parametrised, byte-writable, word-addressed data memory with a valid/ready request channel and a valid/ready response channel.
- Adds a registered read, byte strobes, alignment and range error detection, single-entry response backpressure, and optional zero-clear after reset.
- Sits between the core load/store unit and on-chip data storage.

Parameters:
DATA_W, 32, word width in bits; power of two, at least 8.
ADDR_W, 32, byte-address width.
DEPTH, 512, number of words; power of two.
CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests.

Ports:
clk_i  in  1  clock; all state updates on rising edge.
rst_ni  in  1  asynchronous active-low reset.
req_valid_i  in  1  request present.
req_ready_o  out  1  request accepted when valid and ready are both high.
req_we_i  in  1  1 = write, 0 = read.
req_addr_i  in  ADDR_W  byte address.
req_wdata_i  in  DATA_W  write data.
req_be_i  in  DATA_W/8  byte enables; writes only.
rsp_valid_o  out  1  response present.
rsp_ready_i  in  1  response consumed when valid and ready are both high.
rsp_rdata_o  out  DATA_W  read data; 0 for writes and errors.
rsp_err_o  out  1  misaligned or out-of-range request.
init_done_o  out  1  high once the clear sequence is finished; stays high until next reset.

Behaviour:
- Constants: OFFS = log2(DATA_W/8). Word index idx = req_addr_i[ADDR_W-1:OFFS].
- Reset (async assert, sync deassert) drives these values:
  - req_ready_o = 0, rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, init_done_o = 0.
  - FSM = INIT, clear counter = 0.
  - Memory array contents are not reset.
- FSM states INIT, RUN.
- INIT, CLEAR_ON_RESET = 1:
  - Each cycle writes 0 to mem[cnt], then cnt++.
  - After the write at cnt = DEPTH-1, goes to RUN on the next edge and sets init_done_o.
  - Exactly DEPTH cycles are spent in INIT.
- INIT, CLEAR_ON_RESET = 0: goes to RUN on the first edge after reset release.
- req_ready_o = (state == RUN) && (!rsp_valid_o || rsp_ready_i). It is combinational from registered state and rsp_ready_i.
- Accept (valid && ready) with addr[OFFS-1:0] != 0 or idx >= DEPTH:
  - Error response: rsp_err_o = 1, rsp_rdata_o = 0.
  - Memory is not modified.
- Accepted write: for each byte b with req_be_i[b] = 1, mem[idx][8b+7:8b] <= wdata byte b. Response has rdata = 0, err = 0. be = 0 is legal: no change, normal response.
- Accepted read: rsp_rdata_o <= mem[idx] on the acceptance edge. Read-data latency is 1 cycle.
- Response timing and ordering:
  - rsp_valid_o rises the edge after acceptance.
  - A write followed by a read of the same word on the next accepted cycle returns the new data.
- Backpressure:
  - While rsp_valid_o && !rsp_ready_i, rsp_* hold stable and req_ready_o = 0.
  - On rsp_ready_i with no new accept, rsp_valid_o drops to 0 on the next edge.
  - Accept and consume in the same cycle: the new response replaces the old one with no bubble. This gives a throughput of 1 request per cycle.
- Ordering: responses return in request order; at most one response is outstanding.
- Reset mid-operation: the pending response is discarded and the FSM restarts INIT. A write accepted in the same cycle as reset assertion is not guaranteed.
- Requests during INIT are not accepted. Holding req_valid_i in INIT is legal.

Decomposition:
- Package memory_pkg:
  - FSM state enum (INIT, RUN).
  - Function clog2-based offset computation.
  - Default parameter constants.
- Sub-module mem_bank: the byte-writable DEPTH x DATA_W array.
  - One write port with per-byte enables.
  - One registered read port.
  - The top muxes the clear writes onto this port during INIT.

Test Plan:
- Reset release, CLEAR_ON_RESET = 1, DEPTH = 512 -> init_done_o rises exactly 512 cycles later; a read of address 0x7FC returns 0x00000000 with err = 0.
- Write 0xDEADBEEF at 0x10 with be = 0xF, then write 0x000000AA at 0x10 with be = 0x1, then read 0x10 -> 0xDEADBEAA.
- Read 0x12 (misaligned) -> err = 1, rdata = 0. Write 0x800 (idx 512 = DEPTH) -> err = 1, memory unchanged.
- Back-to-back write then read of 0x20 with rsp_ready_i = 1 -> one response per cycle; the read returns the written data.
- Hold rsp_ready_i = 0 for 3 cycles after a read -> rsp_* stable, req_ready_o = 0 throughout; on release the next request is accepted in the same cycle.
- Assert rst_ni low at init cycle 100 -> all outputs return to 0 immediately; after release, init takes the full 512 cycles again.
